// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request at a time,
// responses buffered in a DEPTH-entry FIFO toward decode, flushed on redirect.
module fetch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h1C00_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirectValid,
  input  logic [DATA_WIDTH-1:0] redirectPC,
  output logic                  imemReqValid,
  output logic [DATA_WIDTH-1:0] imemReqAddr,
  input  logic                  imemReqReady,
  input  logic                  imemRespValid,
  input  logic [31:0]           imemRespInstr,
  output logic                  outValid,
  output logic [31:0]           outInstr,
  output logic [DATA_WIDTH-1:0] outPC,
  input  logic                  outReady
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] RESET_ADDR = DATA_WIDTH'(RESET_PC);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } entry_t;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  entry_t                mem_q [DEPTH];
  entry_t                head_c;

  logic req_gate_c;
  logic issue_c;
  logic push_c;
  logic pop_c;
  logic not_empty_c;

  // The issue gate on count guarantees a free slot for the response.
  assign req_gate_c  = (state_q == S_FETCH) && (count_q < DEPTH_CNT) && !redirectValid;
  assign issue_c     = req_gate_c && imemReqReady;
  assign not_empty_c = (count_q != '0);
  assign pop_c       = not_empty_c && outReady;
  assign head_c      = mem_q[rd_ptr_q];

  assign imemReqValid = req_gate_c && reset;
  assign imemReqAddr  = fetch_pc_q;
  assign outValid     = not_empty_c;
  assign outInstr     = not_empty_c ? head_c.instr : 32'd0;
  assign outPC        = not_empty_c ? head_c.pc : '0;

  // Next-state: request/response sequencing, then queue bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!redirectValid && issue_c) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirectValid) begin
          state_d = imemRespValid ? S_FETCH : S_DROP;
        end else if (imemRespValid) begin
          push_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (imemRespValid) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Redirect wins over push and pop; a popped head was still delivered.
    if (redirectValid) begin
      fetch_pc_d = redirectPC & ALIGN_MASK;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_ADDR;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {req_pc_q, imemRespInstr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_fetch_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam logic [31:0] SALT   = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespInstr;
  logic        outValid;
  logic [31:0] outInstr;
  logic [31:0] outPC;
  logic        outReady;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirectValid (redirectValid),
    .redirectPC    (redirectPC),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRespValid (imemRespValid),
    .imemRespInstr (imemRespInstr),
    .outValid      (outValid),
    .outInstr      (outInstr),
    .outPC         (outPC),
    .outReady      (outReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: a plain queue plus "request in flight / to be discarded" flags.
  ent_t        m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_reqpc;
  bit          m_busy;
  bit          m_drop;

  // Memory responder state.
  bit          mem_pend;
  int          mem_lat;
  logic [31:0] mem_instr;

  // Per-cycle stimulus knobs.
  bit          d_rv, d_ready, d_outrdy, d_spur, d_lat_rand, d_salt_rand;
  logic [31:0] d_rpc;
  int          d_lat_fix;

  // DUT outputs sampled at the falling edge.
  bit          s_reqv, s_outv;
  logic [31:0] s_addr, s_outpc, s_outinstr;

  ent_t        dut_deliv[$];
  logic [31:0] req_log[$];

  int n_chk;
  int n_fail;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_fetch = RST_PC;
    m_reqpc = 32'd0;
    m_busy  = 1'b0;
    m_drop  = 1'b0;
  endfunction

  function automatic bit model_reqv();
    return !m_busy && (m_q.size() < int'(DEPTH)) && !d_rv;
  endfunction

  task automatic compare();
    bit exp_reqv;
    s_reqv     = imemReqValid;
    s_addr     = imemReqAddr;
    s_outv     = outValid;
    s_outpc    = outPC;
    s_outinstr = outInstr;
    exp_reqv   = model_reqv();
    chk("imemReqValid", 64'(s_reqv), 64'(exp_reqv));
    if (exp_reqv) chk("imemReqAddr", 64'(s_addr), 64'(m_fetch));
    chk("outValid", 64'(s_outv), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("outPC", 64'(s_outpc), 64'(m_q[0].pc));
      chk("outInstr", 64'(s_outinstr), 64'(m_q[0].instr));
    end
  endtask

  task automatic model_update();
    bit reqv;
    reqv = model_reqv();
    if (d_rv) begin
      m_q.delete();
      m_fetch = d_rpc & ~32'h3;
      if (m_busy) begin
        if (imemRespValid) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (m_q.size() != 0 && d_outrdy) void'(m_q.pop_front());
      if (m_busy && imemRespValid) begin
        if (!m_drop) m_q.push_back('{m_reqpc, imemRespInstr});
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
      if (reqv && d_ready) begin
        m_reqpc = m_fetch;
        m_fetch = m_fetch + 32'd4;
        m_busy  = 1'b1;
      end
    end
  endtask

  task automatic mem_update();
    if (imemRespValid && mem_pend) mem_pend = 1'b0;
    if (s_reqv && d_ready) begin
      chk("one_outstanding", 64'(mem_pend), 64'(0));
      req_log.push_back(s_addr);
      mem_pend  = 1'b1;
      mem_lat   = d_lat_rand ? int'($urandom_range(0, 3)) : d_lat_fix;
      mem_instr = d_salt_rand ? $urandom : (s_addr ^ SALT);
    end
    if (s_outv && d_outrdy) dut_deliv.push_back('{s_outpc, s_outinstr});
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step();
    redirectValid = d_rv;
    redirectPC    = d_rpc;
    imemReqReady  = d_ready;
    outReady      = d_outrdy;
    if (mem_pend && mem_lat == 0) begin
      imemRespValid = 1'b1;
      imemRespInstr = mem_instr;
    end else begin
      imemRespValid = !mem_pend && d_spur && ($urandom_range(0, 19) == 0);
      imemRespInstr = $urandom;
      if (mem_pend) mem_lat--;
    end
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    mem_update();
    #1;
  endtask

  task automatic set_knobs(bit ready, bit outrdy, int lat);
    d_rv = 1'b0; d_rpc = 32'd0; d_ready = ready; d_outrdy = outrdy;
    d_spur = 1'b0; d_lat_rand = 1'b0; d_salt_rand = 1'b0; d_lat_fix = lat;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirectValid = 1'b0; redirectPC = 32'd0; imemReqReady = 1'b0;
    imemRespValid = 1'b0; imemRespInstr = 32'd0; outReady = 1'b0;
    model_reset();
    mem_pend = 1'b0; mem_lat = 0;
    dut_deliv.delete(); req_log.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0;
    redirectValid = 1'b0; redirectPC = 32'd0; imemReqReady = 1'b0;
    imemRespValid = 1'b0; imemRespInstr = 32'd0; outReady = 1'b0;
    model_reset();
    mem_pend = 1'b0; mem_lat = 0; mem_instr = 32'd0;
    set_knobs(1'b0, 1'b0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imemReqValid", 64'(imemReqValid), 64'(0));
    chk("rst_imemReqAddr", 64'(imemReqAddr), 64'(32'h1C00_0000));
    chk("rst_outValid", 64'(outValid), 64'(0));
    chk("rst_outInstr", 64'(outInstr), 64'(0));
    chk("rst_outPC", 64'(outPC), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;

    // Streaming with 1-cycle memory and decode always ready
    set_knobs(1'b1, 1'b1, 0);
    step();
    chk("first_req_valid", 64'(s_reqv), 64'(1));
    chk("first_req_addr", 64'(s_addr), 64'(32'h1C00_0000));
    repeat (7) step();
    chk("stream_count", 64'(dut_deliv.size() >= 3), 64'(1));
    if (dut_deliv.size() >= 3) begin
      chk("stream_pc0", 64'(dut_deliv[0].pc), 64'(32'h1C00_0000));
      chk("stream_pc1", 64'(dut_deliv[1].pc), 64'(32'h1C00_0004));
      chk("stream_pc2", 64'(dut_deliv[2].pc), 64'(32'h1C00_0008));
      chk("stream_in0", 64'(dut_deliv[0].instr), 64'(32'h1C00_0000 ^ SALT));
      chk("stream_in2", 64'(dut_deliv[2].instr), 64'(32'h1C00_0008 ^ SALT));
    end

    // Fill with decode stalled, then drain in order
    do_reset();
    set_knobs(1'b1, 1'b0, 0);
    repeat (10) step();
    chk("fill_reqs", 64'(req_log.size()), 64'(4));
    chk("fill_gate", 64'(s_reqv), 64'(0));
    chk("fill_model_size", 64'(m_q.size()), 64'(4));
    chk("fill_head", 64'(s_outpc), 64'(32'h1C00_0000));
    d_outrdy = 1'b1;
    repeat (10) step();
    chk("drain_count", 64'(dut_deliv.size() >= 4), 64'(1));
    if (dut_deliv.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("drain_pc%0d", i), 64'(dut_deliv[i].pc), 64'(32'h1C00_0000 + 32'(4 * i)));
    end
    chk("resume_count", 64'(req_log.size() >= 5), 64'(1));
    if (req_log.size() >= 5) chk("resume_addr", 64'(req_log[4]), 64'(32'h1C00_0010));

    // Redirect while waiting; late response must be dropped
    do_reset();
    set_knobs(1'b1, 1'b0, 3);
    step();
    d_rv = 1'b1; d_rpc = 32'h1C00_0100;
    step();
    d_rv = 1'b0;
    step();
    chk("drop_no_req", 64'(s_reqv), 64'(0));
    step(); step();
    d_lat_fix = 0;
    step();
    chk("drop_outValid", 64'(s_outv), 64'(0));
    chk("drop_next_req", 64'(s_reqv), 64'(1));
    chk("drop_next_addr", 64'(s_addr), 64'(32'h1C00_0100));

    // Redirect with simultaneous response and pop
    do_reset();
    set_knobs(1'b1, 1'b0, 0);
    repeat (3) step();
    d_rv = 1'b1; d_rpc = 32'h1C00_0203; d_outrdy = 1'b1;
    step();
    d_rv = 1'b0; d_outrdy = 1'b0;
    step();
    chk("flush_outValid", 64'(s_outv), 64'(0));
    chk("flush_req_valid", 64'(s_reqv), 64'(1));
    chk("flush_req_addr", 64'(s_addr), 64'(32'h1C00_0200));
    chk("flush_delivered", 64'(dut_deliv.size()), 64'(1));
    if (dut_deliv.size() == 1) chk("flush_deliv_pc", 64'(dut_deliv[0].pc), 64'(32'h1C00_0000));

    // PC wrap at the top of the address space
    do_reset();
    set_knobs(1'b0, 1'b1, 0);
    d_rv = 1'b1; d_rpc = 32'hFFFF_FFFC;
    step();
    d_rv = 1'b0; d_ready = 1'b1;
    repeat (3) step();
    chk("wrap_reqs", 64'(req_log.size()), 64'(2));
    if (req_log.size() == 2) begin
      chk("wrap_addr0", 64'(req_log[0]), 64'(32'hFFFF_FFFC));
      chk("wrap_addr1", 64'(req_log[1]), 64'(32'h0000_0000));
    end

    // Reset mid-WAIT; stale response after release is ignored
    do_reset();
    set_knobs(1'b1, 1'b0, 1);
    step();
    step();
    reset = 1'b0;
    model_reset();
    redirectValid = 1'b0; imemRespValid = 1'b0;
    #1;
    chk("midrst_reqv", 64'(imemReqValid), 64'(0));
    chk("midrst_outv", 64'(outValid), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    d_ready = 1'b0;
    step();
    chk("stale_req_valid", 64'(s_reqv), 64'(1));
    chk("stale_req_addr", 64'(s_addr), 64'(32'h1C00_0000));
    d_ready = 1'b1;
    step();
    chk("stale_outValid", 64'(s_outv), 64'(0));
    repeat (3) step();

    // Random traffic against the model
    do_reset();
    set_knobs(1'b1, 1'b1, 0);
    d_spur = 1'b1; d_lat_rand = 1'b1; d_salt_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      int pr;
      pr = (((c / 400) % 2) == 0) ? 8 : 2;
      d_ready  = ($urandom_range(0, 9) < 7);
      d_outrdy = (int'($urandom_range(0, 9)) < pr);
      d_rv     = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 2))
        0:       d_rpc = $urandom;
        1:       d_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: d_rpc = RST_PC + 32'($urandom_range(0, 255));
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: PC/address width; legal range 32..64.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, >=2.
REQ-003 Parameter RESET_PC, default 32'h1C00_0000: first fetch address, zero-extended to DATA_WIDTH.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 redirectValid  in  1  branch/jump redirect request from execute.
REQ-007 redirectPC  in  DATA_WIDTH  redirect target.
REQ-008 imemReqValid  out  1  fetch request valid.
REQ-009 imemReqAddr  out  DATA_WIDTH  fetch address.
REQ-010 imemReqReady  in  1  memory accepts request.
REQ-011 imemRespValid  in  1  instruction return valid; variable latency >=1 cycle.
REQ-012 imemRespInstr  in  32  returned instruction.
REQ-013 outValid  out  1  queue head valid toward decode.
REQ-014 outInstr  out  32  queue head instruction.
REQ-015 outPC  out  DATA_WIDTH  PC of queue head.
REQ-016 outReady  in  1  decode consumes head.

Function
REQ-017 Handshakes SHALL complete only on a cycle where valid and ready are both 1.
REQ-018 At most one memory request SHALL be outstanding.
REQ-019 State machine SHALL have states FETCH, WAIT, DROP.
REQ-020 FETCH: imemReqValid=1 iff count<DEPTH and redirectValid=0; imemReqAddr=fetchPC.
REQ-021 FETCH, request handshake, no redirect: latch reqPC=fetchPC, fetchPC+=4 (wraps modulo 2^DATA_WIDTH), go WAIT.
REQ-022 WAIT, imemRespValid=1, no redirect: push {reqPC, imemRespInstr} into queue, go FETCH.
REQ-023 Redirect: fetchPC<=redirectPC with bits[1:0] forced to 0; queue flushed (count=0, pointers reset) in the same edge.
REQ-024 Redirect in FETCH: go/stay FETCH; new request may issue next cycle.
REQ-025 Redirect in WAIT with imemRespValid=0: go DROP; same-cycle imemRespValid=1: response discarded, go FETCH.
REQ-026 DROP: imemReqValid=0; next imemRespValid discarded, go FETCH.
REQ-027 imemRespValid outside WAIT/DROP SHALL be ignored.
REQ-028 outValid = (count!=0); outInstr/outPC SHALL be the oldest entry, held stable until popped.
REQ-029 Simultaneous push and pop SHALL leave count unchanged, preserving FIFO order.
REQ-030 Redirect SHALL take priority over push and pop in the same cycle; popped head still counts as delivered.
REQ-031 Issue gate count<DEPTH guarantees room for the response; push into a full queue SHALL never occur.
REQ-032 count SHALL be clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Reset
REQ-033 While reset=0: state=FETCH, fetchPC=RESET_PC, count=0, pointers=0, imemReqValid=0, outValid=0, outInstr=0, outPC=0.
REQ-034 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late response after release arrives in FETCH and is ignored.
REQ-035 First request SHALL appear the first cycle after reset release with imemReqAddr=RESET_PC.

Verification
REQ-036 Release reset, imemReqReady=1, 1-cycle response, outReady=1 -> outPC sequence 1C000000, 1C000004, 1C000008 with matching instrs.
REQ-037 outReady=0, DEPTH=4 -> exactly 4 entries fill, imemReqValid stays 0 at count=4; set outReady=1 -> entries drain in order, fetch resumes at 1C000010.
REQ-038 Redirect to 1C000100 while in WAIT, response arrives 3 cycles later -> response discarded, queue empty, next request addr 1C000100.
REQ-039 Redirect to 1C000203 with simultaneous response and pop -> queue flushed, next imemReqAddr=1C000200.
REQ-040 fetchPC=FFFFFFFC, request accepted -> next imemReqAddr=00000000.
REQ-041 reset=0 asserted in WAIT, released, stale imemRespValid=1 -> no push, outValid=0, request to RESET_PC.
